// File: rtl/bsg_upstream_link_ctrl_if.sv
// Core-side word handshake, credit-return token and serialized I/O beat outputs.
// master = core producer / pad side, slave = link controller.
interface bsg_upstream_link_ctrl_if #(
    parameter int CH_WIDTH   = 8,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_W      = 7
);
    logic [DATA_WIDTH-1:0] core_data_in;
    logic                  core_valid_in;
    logic                  core_ready_out;
    logic                  io_token;
    logic                  io_valid_out;
    logic [CH_WIDTH-1:0]   io_data_out_ch0;
    logic [CH_WIDTH-1:0]   io_data_out_ch1;
    logic [CNT_W-1:0]      credit_avail;
    logic                  token_err;

    modport master (
        output core_data_in, core_valid_in, io_token,
        input  core_ready_out, io_valid_out, io_data_out_ch0, io_data_out_ch1,
               credit_avail, token_err
    );

    modport slave (
        input  core_data_in, core_valid_in, io_token,
        output core_ready_out, io_valid_out, io_data_out_ch0, io_data_out_ch1,
               credit_avail, token_err
    );
endinterface

// File: rtl/bsg_upstream_link_ctrl.sv
// Credit-based upstream link sequencer: serializes 64-bit core words into 4 beats
// on two byte channels, gating acceptance on credits returned by io_token pulses.
module bsg_upstream_link_ctrl #(
    parameter int CREDIT_MAX    = 64,
    parameter int TOKEN_CREDITS = 8,
    parameter int CH_WIDTH      = 8,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    bsg_upstream_link_ctrl_if.slave  link
);
    localparam int CNT_W = 7;
    localparam int HALF  = DATA_WIDTH / 2;

    typedef enum logic {IDLE, SEND} state_e;

    state_e            state, state_n;
    logic [1:0]        beat, beat_n;
    logic [HALF-1:0]   data_cycle_0, data_cycle_1;
    logic [CNT_W-1:0]  sent_cnt, finish_cnt;
    logic [CNT_W-1:0]  outstanding;
    logic              has_credit;
    logic              ready;
    logic              accept;
    logic              token_err_q;
    logic [CH_WIDTH-1:0] ch0, ch1;

    // Mod-128 difference stays unambiguous because CREDIT_MAX <= 64.
    assign outstanding = sent_cnt - finish_cnt;
    assign has_credit  = outstanding < CNT_W'(CREDIT_MAX);
    assign ready       = has_credit && (state == IDLE || beat == 2'd3);
    assign accept      = link.core_valid_in && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= 2'd0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end
    end

    always_comb begin
        state_n = state;
        beat_n  = beat;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SEND;
                    beat_n  = 2'd0;
                end
            end
            SEND: begin
                if (beat == 2'd3) begin
                    beat_n  = 2'd0;
                    state_n = accept ? SEND : IDLE;
                end else begin
                    beat_n = beat + 2'd1;
                end
            end
            default: begin
                state_n = IDLE;
                beat_n  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_cycle_0 <= '0;
            data_cycle_1 <= '0;
            sent_cnt     <= '0;
        end else if (accept) begin
            data_cycle_0 <= link.core_data_in[HALF-1:0];
            data_cycle_1 <= link.core_data_in[DATA_WIDTH-1:HALF];
            sent_cnt     <= sent_cnt + CNT_W'(1);
        end
    end

    // Token check uses the pre-accept count; an over-return clamps to fully credited.
    always_ff @(posedge clk) begin
        if (rst) begin
            finish_cnt  <= '0;
            token_err_q <= 1'b0;
        end else begin
            token_err_q <= 1'b0;
            if (link.io_token) begin
                if (outstanding >= CNT_W'(TOKEN_CREDITS)) begin
                    finish_cnt <= finish_cnt + CNT_W'(TOKEN_CREDITS);
                end else begin
                    finish_cnt  <= sent_cnt;
                    token_err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ch0 = '0;
        ch1 = '0;
        if (state == SEND) begin
            case (beat)
                2'd0: begin ch0 = data_cycle_0[7:0];   ch1 = data_cycle_0[15:8];  end
                2'd1: begin ch0 = data_cycle_0[23:16]; ch1 = data_cycle_0[31:24]; end
                2'd2: begin ch0 = data_cycle_1[7:0];   ch1 = data_cycle_1[15:8];  end
                default: begin ch0 = data_cycle_1[23:16]; ch1 = data_cycle_1[31:24]; end
            endcase
        end
    end

    assign link.core_ready_out  = ready;
    assign link.io_valid_out    = (state == SEND);
    assign link.io_data_out_ch0 = ch0;
    assign link.io_data_out_ch1 = ch1;
    assign link.credit_avail    = CNT_W'(CREDIT_MAX) - outstanding;
    assign link.token_err       = token_err_q;
endmodule

// File: tb/tb_bsg_upstream_link_ctrl.sv
// Randomized bench for bsg_upstream_link_ctrl against a beat-queue / outstanding-count model.
module tb_bsg_upstream_link_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        token = 1'b0;
    logic [63:0] data = '0;
    bit          sel = 1'b0;   // 0: CREDIT_MAX=64 instance, 1: CREDIT_MAX=8 instance

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding words as an integer, pending beats as a queue.
    int          m_out = 0;
    int          m_cm  = 64;
    bit          m_terr = 1'b0;
    logic [15:0] m_q[$];
    int          n_acc = 0;

    logic [25:0] obs, expv;

    always #5 clk = ~clk;

    bsg_upstream_link_ctrl_if u64 ();
    bsg_upstream_link_ctrl_if u8 ();

    assign u64.core_valid_in = sel ? 1'b0 : valid;
    assign u64.core_data_in  = data;
    assign u64.io_token      = sel ? 1'b0 : token;
    assign u8.core_valid_in  = sel ? valid : 1'b0;
    assign u8.core_data_in   = data;
    assign u8.io_token       = sel ? token : 1'b0;

    bsg_upstream_link_ctrl #(.CREDIT_MAX(64), .TOKEN_CREDITS(8)) dut (
        .clk(clk), .rst(rst), .link(u64));
    bsg_upstream_link_ctrl #(.CREDIT_MAX(8), .TOKEN_CREDITS(8)) dut8 (
        .clk(clk), .rst(rst), .link(u8));

    wire       o_valid  = sel ? u8.io_valid_out    : u64.io_valid_out;
    wire [7:0] o_ch0    = sel ? u8.io_data_out_ch0 : u64.io_data_out_ch0;
    wire [7:0] o_ch1    = sel ? u8.io_data_out_ch1 : u64.io_data_out_ch1;
    wire       o_ready  = sel ? u8.core_ready_out  : u64.core_ready_out;
    wire [6:0] o_credit = sel ? u8.credit_avail    : u64.credit_avail;
    wire       o_terr   = sel ? u8.token_err       : u64.token_err;

    function automatic logic exp_ready();
        return (m_out < m_cm) && (m_q.size() <= 1);
    endfunction

    function automatic logic [25:0] exp_vec();
        logic [15:0] b;
        b = (m_q.size() > 0) ? m_q[0] : 16'h0;
        return {m_q.size() > 0, b, exp_ready(), 7'(m_cm - m_out), m_terr};
    endfunction

    function automatic logic [25:0] obs_vec();
        return {o_valid, o_ch1, o_ch0, o_ready, o_credit, o_terr};
    endfunction

    // Advance one clock: sample inputs against the model, then settle past the negedge.
    task automatic tick();
        bit acc;
        bit terr_n;
        acc    = valid && exp_ready();
        terr_n = 1'b0;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_out  = 0;
            m_terr = 1'b0;
        end else begin
            if (m_q.size() > 0) m_q.delete(0);
            if (token) begin
                if (m_out >= 8) m_out -= 8;
                else begin m_out = 0; terr_n = 1'b1; end
            end
            if (acc) begin
                m_out++;
                n_acc++;
                m_q.push_back(data[15:0]);
                m_q.push_back(data[31:16]);
                m_q.push_back(data[47:32]);
                m_q.push_back(data[63:48]);
            end
            m_terr = terr_n;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit s);
        sel = s; m_cm = s ? 8 : 64;
        valid = 0; token = 0; rst = 1;
        tick(); tick();
        rst = 0;
        n_acc = 0;
    endtask

    task automatic test_reset();
        do_reset(0);
        obs = obs_vec(); checks++;
        if (obs !== {1'b0, 16'h0, 1'b1, 7'd64, 1'b0}) begin
            errors++; $display("FAIL reset obs=%h exp=%h", obs, {1'b0, 16'h0, 1'b1, 7'd64, 1'b0});
        end
        obs = obs_vec(); expv = exp_vec(); checks++;
        if (obs !== expv) begin errors++; $display("FAIL reset_model obs=%h exp=%h", obs, expv); end
    endtask

    task automatic test_single();
        logic [15:0] seen[$];
        logic [15:0] want[4];
        want[0] = 16'h2211; want[1] = 16'h4433; want[2] = 16'h6655; want[3] = 16'h8877;
        do_reset(0);
        valid = 1; data = 64'h8877665544332211;
        for (int c = 0; c < 7; c++) begin
            obs = obs_vec(); expv = exp_vec(); checks++;
            if (obs !== expv) begin errors++; $display("FAIL single cyc%0d obs=%h exp=%h", c, obs, expv); end
            if (o_valid) seen.push_back({o_ch1, o_ch0});
            tick();
            valid = 0;
        end
        checks++;
        if (seen.size() != 4) begin errors++; $display("FAIL single_beats got=%0d want=4", seen.size()); end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== want[i]) begin errors++; $display("FAIL single_beat%0d got=%h want=%h", i, seen[i], want[i]); end
        end
        checks++;
        if (o_credit !== 7'd63) begin errors++; $display("FAIL single_credit got=%0d want=63", o_credit); end
    endtask

    task automatic test_back_to_back();
        int run, best;
        do_reset(0);
        run = 0; best = 0;
        valid = 1; data = {$urandom, $urandom};
        for (int c = 0; c < 20; c++) begin
            obs = obs_vec(); expv = exp_vec(); checks++;
            if (obs !== expv) begin errors++; $display("FAIL b2b cyc%0d obs=%h exp=%h", c, obs, expv); end
            run  = o_valid ? run + 1 : 0;
            best = (run > best) ? run : best;
            if (valid && exp_ready()) begin
                tick();
                data = {$urandom, $urandom};
                if (n_acc >= 3) valid = 0;
            end else tick();
        end
        checks++;
        if (best != 12) begin errors++; $display("FAIL b2b_run got=%0d want=12", best); end
        checks++;
        if (o_credit !== 7'd61) begin errors++; $display("FAIL b2b_credit got=%0d want=61", o_credit); end
    endtask

    task automatic test_credit_stall();
        do_reset(1);
        valid = 1;
        for (int c = 0; c < 40; c++) begin
            data = {$urandom, $urandom};
            obs = obs_vec(); expv = exp_vec(); checks++;
            if (obs !== expv) begin errors++; $display("FAIL stall cyc%0d obs=%h exp=%h", c, obs, expv); end
            tick();
        end
        checks++;
        if ({o_ready, o_credit} !== {1'b0, 7'd0}) begin
            errors++; $display("FAIL stall_block ready=%b credit=%0d want ready=0 credit=0", o_ready, o_credit);
        end
        token = 1;
        tick();
        token = 0;
        checks++;
        if ({o_ready, o_credit, o_terr} !== {1'b1, 7'd8, 1'b0}) begin
            errors++; $display("FAIL stall_token ready=%b credit=%0d terr=%b want 1/8/0", o_ready, o_credit, o_terr);
        end
        tick();
        valid = 0;
        checks++;
        if ({o_valid, o_credit} !== {1'b1, 7'd7}) begin
            errors++; $display("FAIL stall_resume valid=%b credit=%0d want 1/7", o_valid, o_credit);
        end
        obs = obs_vec(); expv = exp_vec(); checks++;
        if (obs !== expv) begin errors++; $display("FAIL stall_resume_model obs=%h exp=%h", obs, expv); end
        do_reset(0);
    endtask

    task automatic test_token_err();
        do_reset(0);
        valid = 1;
        for (int c = 0; c < 20; c++) begin
            data = {$urandom, $urandom};
            if (n_acc >= 3) valid = 0;
            tick();
        end
        checks++;
        if (o_credit !== 7'd61) begin errors++; $display("FAIL terr_pre credit=%0d want=61", o_credit); end
        token = 1;
        tick();
        token = 0;
        checks++;
        if ({o_terr, o_credit} !== {1'b1, 7'd64}) begin
            errors++; $display("FAIL terr_pulse terr=%b credit=%0d want 1/64", o_terr, o_credit);
        end
        tick();
        checks++;
        if ({o_terr, o_credit} !== {1'b0, 7'd64}) begin
            errors++; $display("FAIL terr_clear terr=%b credit=%0d want 0/64", o_terr, o_credit);
        end
    endtask

    task automatic test_wrap();
        int last_tok;
        int cyc;
        do_reset(0);
        last_tok = 0; cyc = 0;
        while (n_acc < 200 && cyc < 3000) begin
            valid = ($urandom_range(0, 3) != 0);
            data  = {$urandom, $urandom};
            token = valid && exp_ready() && n_acc > 0 && (n_acc % 8 == 0) && last_tok != n_acc;
            if (token) last_tok = n_acc;
            obs = obs_vec(); expv = exp_vec(); checks++;
            if (obs !== expv) begin errors++; $display("FAIL wrap cyc%0d obs=%h exp=%h", cyc, obs, expv); end
            tick();
            cyc++;
        end
        valid = 0; token = 0;
        checks++;
        if (n_acc != 200) begin errors++; $display("FAIL wrap_timeout accepted=%0d want=200", n_acc); end
        obs = obs_vec(); expv = exp_vec(); checks++;
        if (obs !== expv) begin errors++; $display("FAIL wrap_end obs=%h exp=%h", obs, expv); end
    endtask

    task automatic test_reset_mid();
        int beats;
        do_reset(0);
        valid = 1; data = {$urandom, $urandom};
        tick();
        valid = 0;
        for (int c = 0; c < 3; c++) begin
            obs = obs_vec(); expv = exp_vec(); checks++;
            if (obs !== expv) begin errors++; $display("FAIL rstmid beat%0d obs=%h exp=%h", c, obs, expv); end
            if (c < 2) tick();
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (obs_vec() !== {1'b0, 16'h0, 1'b1, 7'd64, 1'b0}) begin
            errors++; $display("FAIL rstmid_abort obs=%h exp=%h", obs_vec(), {1'b0, 16'h0, 1'b1, 7'd64, 1'b0});
        end
        beats = 0;
        valid = 1; data = {$urandom, $urandom};
        for (int c = 0; c < 7; c++) begin
            obs = obs_vec(); expv = exp_vec(); checks++;
            if (obs !== expv) begin errors++; $display("FAIL rstmid_resend cyc%0d obs=%h exp=%h", c, obs, expv); end
            if (o_valid) beats++;
            tick();
            valid = 0;
        end
        checks++;
        if (beats != 4) begin errors++; $display("FAIL rstmid_beats got=%0d want=4", beats); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_stall();
        test_token_err();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
